dmem_responder: RTL and testbench

Data-memory responder for the five-stage RV32I pipeline. It sits on the far side of the memory stage's load/store port: it accepts one request at a time over a valid/ready handshake, services it after a fixed, parameterised latency, and returns load data or a store acknowledgement over a second valid/ready handshake. Memory-stage stalls come from this block's back-pressure. It implements RV32I byte, half and word access semantics and flags illegal accesses.

---
 rtl/dmem_responder.sv | 155 +++++++++++++++
 tb/tb_dmem_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder for the RV32I
// memory stage. Accepts a request, waits a fixed LATENCY, then commits the
// load/store and presents the response until it is taken.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | ready for a request; req_r high
// S_BUSY | request captured, latency counter running down to zero
// S_RESP | response registered and held until rsp_r
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_v,
    output logic        req_r,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_v,
    input  logic        rsp_r,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int       IW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] LAT_M2 = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] mem [DEPTH_WORDS];

    logic        accept, commit;
    logic        op_we;
    logic [2:0]  op_f3;
    logic [31:0] op_addr, op_wdata;
    logic [IW-1:0] op_idx;
    logic        f3_ok, misal, oor, op_err;
    logic [3:0]  op_be;
    logic [31:0] op_wword, rd_word, rd_shift, ld_data;

    assign req_r  = (state == S_IDLE) && rst_n;
    assign rsp_v  = (state == S_RESP);
    assign accept = req_v && req_r;
    // Write and read both land on the edge that enters RESP; a reset on that
    // edge must suppress the write.
    assign commit = rst_n && (state != S_RESP) && (state_nxt == S_RESP);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = (LATENCY == 1) ? S_RESP : S_BUSY;
            S_BUSY: if (cnt == 4'd0) state_nxt = S_RESP;
            S_RESP: if (rsp_r) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Latency down-counter, loaded at accept.
    always_ff @(posedge clk) begin
        if (!rst_n)                            cnt <= 4'd0;
        else if (accept)                       cnt <= LAT_M2;
        else if (state == S_BUSY && cnt != 4'd0) cnt <= cnt - 4'd1;
    end

    // Request capture; inputs are only looked at on the accept edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // With LATENCY==1 the commit edge is the accept edge, so the operands come
    // straight from the request port while still in IDLE.
    always_comb begin
        op_we    = (state == S_IDLE) ? req_we     : we_q;
        op_f3    = (state == S_IDLE) ? req_funct3 : f3_q;
        op_addr  = (state == S_IDLE) ? req_addr   : addr_q;
        op_wdata = (state == S_IDLE) ? req_wdata  : wdata_q;
    end

    // Error classification, byte enables and load extraction.
    always_comb begin
        op_idx = op_addr[IW+1:2];
        if (op_we) f3_ok = !op_f3[2] && (op_f3[1:0] != 2'b11);
        else       f3_ok = (op_f3[1:0] != 2'b11) && !(op_f3[2] && op_f3[1]);
        misal  = ((op_f3[1:0] == 2'b01) && op_addr[0]) ||
                 ((op_f3[1:0] == 2'b10) && (op_addr[1:0] != 2'b00));
        oor    = {2'b00, op_addr[31:2]} >= 32'(DEPTH_WORDS);
        op_err = !f3_ok || misal || oor;

        case (op_f3[1:0])
            2'b00: begin
                op_be    = 4'b0001 << op_addr[1:0];
                op_wword = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                op_be    = 4'b0011 << {op_addr[1], 1'b0};
                op_wword = {2{op_wdata[15:0]}};
            end
            default: begin
                op_be    = 4'b1111;
                op_wword = op_wdata;
            end
        endcase

        rd_word  = mem[op_idx];
        rd_shift = rd_word >> {op_addr[1:0], 3'b000};
        case (op_f3)
            3'b000:  ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b100:  ld_data = {24'd0, rd_shift[7:0]};
            3'b001:  ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b101:  ld_data = {16'd0, rd_shift[15:0]};
            default: ld_data = rd_word;
        endcase
    end

    // Byte-masked store at commit; errored stores leave memory untouched.
    always_ff @(posedge clk) begin
        if (commit && op_we && !op_err) begin
            for (int b = 0; b < 4; b++) begin
                if (op_be[b]) mem[op_idx][8*b +: 8] <= op_wword[8*b +: 8];
            end
        end
    end

    // Registered response, captured at commit and held through RESP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else if (commit) begin
            rsp_err   <= op_err;
            rsp_rdata <= (op_we || op_err) ? 32'd0 : ld_data;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 4, 1) checked against
// a byte-addressed reference memory with RV32I access rules.
module tb_dmem_responder;

    localparam int DEPTH   = 64;
    localparam int LAT [3] = '{2, 4, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst_n, req_v, req_r, req_we, rsp_v, rsp_r, rsp_err;
    logic [2:0]  req_funct3 [3];
    logic [31:0] req_addr [3], req_wdata [3], rsp_rdata [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT[g])) u_dut (
            .clk        (clk),
            .rst_n      (rst_n[g]),
            .req_v      (req_v[g]),
            .req_r      (req_r[g]),
            .req_we     (req_we[g]),
            .req_funct3 (req_funct3[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .rsp_v      (rsp_v[g]),
            .rsp_r      (rsp_r[g]),
            .rsp_rdata  (rsp_rdata[g]),
            .rsp_err    (rsp_err[g])
        );
    end

    int tests = 0;
    int fails = 0;
    logic [7:0] mb [3][DEPTH*4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: byte memory, access size from funct3, little-endian.
    task automatic model(input int d, input bit we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] ed, output logic ee);
        int size;
        bit legal;
        logic [31:0] v;
        size  = 1 << f3[1:0];
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        ee    = !legal || ((a % size) != 0) || ((a / 4) >= DEPTH);
        ed    = 32'd0;
        if (!ee) begin
            if (we) begin
                for (int i = 0; i < size; i++) mb[d][a + i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < size; i++) v = v | (32'(mb[d][a + i]) << (8*i));
                if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
                ed = v;
            end
        end
    endtask

    // One full transaction; called and returning on a negedge.
    task automatic txn(input int d, input bit we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int hold, input string tag, output logic [31:0] obs);
        logic [31:0] ed, r0;
        logic ee, e0;
        int n;
        model(d, we, f3, a, wd, ed, ee);
        req_v[d] = 1'b1; req_we[d] = we; req_funct3[d] = f3;
        req_addr[d] = a; req_wdata[d] = wd; rsp_r[d] = (hold == 0);
        n = 0;
        while (req_r[d] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " accept"}, 32'(req_r[d]), 32'd1);
        @(posedge clk);
        #1;
        req_v[d] = 1'b0; req_we[d] = 1'($urandom); req_funct3[d] = 3'($urandom);
        req_addr[d] = $urandom; req_wdata[d] = $urandom;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rsp_v[d] !== 1'b1 && n < 20);
        chk({tag, " latency"}, 32'(n), 32'(LAT[d]));
        r0 = rsp_rdata[d];
        e0 = rsp_err[d];
        obs = r0;
        chk({tag, " rdata"}, r0, ed);
        chk({tag, " err"}, 32'(e0), 32'(ee));
        for (int k = 0; k < hold; k++) begin
            req_v[d] = 1'b1; req_we[d] = 1'b1; req_funct3[d] = 3'd2;
            req_addr[d] = 32'h10; req_wdata[d] = $urandom;
            @(negedge clk);
            chk({tag, " hold rsp_v"}, 32'(rsp_v[d]), 32'd1);
            chk({tag, " hold rdata"}, rsp_rdata[d], r0);
            chk({tag, " hold err"}, 32'(rsp_err[d]), 32'(e0));
            chk({tag, " hold req_r"}, 32'(req_r[d]), 32'd0);
        end
        req_v[d] = 1'b0;
        rsp_r[d] = 1'b1;
        @(negedge clk);
        chk({tag, " post rsp_v"}, 32'(rsp_v[d]), 32'd0);
        chk({tag, " post req_r"}, 32'(req_r[d]), 32'd1);
    endtask

    // Directed steps followed by randomized traffic.
    initial begin
        logic [31:0] o, a;
        logic [31:0] ed;
        logic ee;
        logic [2:0] f3;
        bit we;
        int acc, rv;
        logic seen;

        rst_n = 3'b000; req_v = 3'b000; rsp_r = 3'b000; req_we = 3'b000;
        for (int d = 0; d < 3; d++) begin
            req_funct3[d] = 3'd0; req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst req_r low", 32'(req_r[0]), 32'd0);
        rst_n = 3'b111;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst%0d req_r", d), 32'(req_r[d]), 32'd1);
            chk($sformatf("rst%0d rsp_v", d), 32'(rsp_v[d]), 32'd0);
            chk($sformatf("rst%0d rdata", d), rsp_rdata[d], 32'd0);
            chk($sformatf("rst%0d err", d), 32'(rsp_err[d]), 32'd0);
        end

        for (int i = 0; i < DEPTH; i++) txn(0, 1'b1, 3'd2, 32'(i * 4), $urandom, 0, "init", o);

        txn(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, "sw10", o);
        txn(0, 1'b0, 3'd2, 32'h10, 32'h0, 0, "lw10", o);
        chk("lw10 value", o, 32'hDEADBEEF);
        txn(0, 1'b1, 3'd2, 32'h10, 32'h0, 0, "sw10 zero", o);
        txn(0, 1'b1, 3'd0, 32'h13, 32'h80, 0, "sb13", o);
        txn(0, 1'b0, 3'd2, 32'h10, 32'h0, 1, "lw10 after sb", o);
        chk("sb word", o, 32'h8000_0000);
        txn(0, 1'b0, 3'd0, 32'h13, 32'h0, 0, "lb13", o);
        chk("lb value", o, 32'hFFFF_FF80);
        txn(0, 1'b0, 3'd4, 32'h13, 32'h0, 0, "lbu13", o);
        chk("lbu value", o, 32'h0000_0080);
        txn(0, 1'b1, 3'd1, 32'h12, 32'h8001, 0, "sh12", o);
        txn(0, 1'b0, 3'd1, 32'h12, 32'h0, 0, "lh12", o);
        chk("lh value", o, 32'hFFFF_8001);
        txn(0, 1'b0, 3'd5, 32'h12, 32'h0, 0, "lhu12", o);
        chk("lhu value", o, 32'h0000_8001);

        txn(0, 1'b0, 3'd2, 32'h11, 32'h0, 0, "lw misaligned", o);
        txn(0, 1'b1, 3'd1, 32'h13, 32'h1234, 0, "sh misaligned", o);
        txn(0, 1'b0, 3'd2, 32'h10, 32'h0, 0, "lw after bad sh", o);
        chk("bad sh no write", o, 32'h8001_0000);
        txn(0, 1'b0, 3'd2, 32'(4 * DEPTH), 32'h0, 0, "lw out of range", o);
        txn(0, 1'b0, 3'd3, 32'h10, 32'h0, 0, "ld funct3 011", o);
        txn(0, 1'b1, 3'd4, 32'h14, 32'h5555, 0, "st funct3 100", o);

        txn(0, 1'b0, 3'd2, 32'h10, 32'h0, 5, "backpressure", o);
        txn(0, 1'b0, 3'd2, 32'h10, 32'h0, 0, "lw after bp", o);
        chk("bp no stray write", o, 32'h8001_0000);

        for (int k = 0; k < 80; k++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom);
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = 32'($urandom_range(0, DEPTH * 4 - 1));
            txn(0, we, f3, a, $urandom, int'($urandom_range(0, 2)), "rand", o);
        end

        // LATENCY=4: reset while the store is still in BUSY.
        txn(1, 1'b1, 3'd2, 32'h20, 32'h22222222, 0, "l4 sw old", o);
        req_v[1] = 1'b1; req_we[1] = 1'b1; req_funct3[1] = 3'd2;
        req_addr[1] = 32'h20; req_wdata[1] = 32'h11111111; rsp_r[1] = 1'b1;
        chk("l4 ready before", 32'(req_r[1]), 32'd1);
        @(posedge clk);
        #1;
        req_v[1] = 1'b0;
        seen = rsp_v[1];
        @(negedge clk);
        rst_n[1] = 1'b0;
        #1;
        chk("l4 req_r in reset", 32'(req_r[1]), 32'd0);
        repeat (2) begin
            @(negedge clk);
            seen = seen | rsp_v[1];
        end
        rst_n[1] = 1'b1;
        @(negedge clk);
        chk("l4 req_r after release", 32'(req_r[1]), 32'd1);
        repeat (5) begin
            @(negedge clk);
            seen = seen | rsp_v[1];
        end
        chk("l4 no response", 32'(seen), 32'd0);
        txn(1, 1'b0, 3'd2, 32'h20, 32'h0, 0, "l4 lw", o);
        chk("l4 store dropped", o, 32'h22222222);
        txn(1, 1'b0, 3'd0, 32'h21, 32'h0, 2, "l4 lb", o);

        // LATENCY=1: back-to-back with rsp_r tied high.
        txn(2, 1'b1, 3'd2, 32'h40, 32'h12345678, 0, "l1 sw", o);
        txn(2, 1'b0, 3'd2, 32'h40, 32'h0, 0, "l1 lw", o);
        chk("l1 lw value", o, 32'h12345678);
        txn(2, 1'b0, 3'd1, 32'h42, 32'h0, 0, "l1 lh", o);
        chk("l1 lh value", o, 32'h00001234);
        model(2, 1'b1, 3'd2, 32'h44, 32'hA5A5A5A5, ed, ee);
        req_v[2] = 1'b1; req_we[2] = 1'b1; req_funct3[2] = 3'd2;
        req_addr[2] = 32'h44; req_wdata[2] = 32'hA5A5A5A5; rsp_r[2] = 1'b1;
        acc = 0;
        rv = 0;
        for (int k = 0; k < 12; k++) begin
            if (req_r[2] === 1'b1) acc++;
            if (rsp_v[2] === 1'b1) rv++;
            @(negedge clk);
        end
        req_v[2] = 1'b0;
        repeat (2) @(negedge clk);
        chk("l1 accepts in 12", 32'(acc), 32'd6);
        chk("l1 responses in 12", 32'(rv), 32'd6);
        txn(2, 1'b0, 3'd2, 32'h44, 32'h0, 0, "l1 lw44", o);
        chk("l1 lw44 value", o, 32'hA5A5A5A5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time limit in case a wait ever escapes its bound.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
        $fatal(1, "time limit");
    end

endmodule
